// File: rtl/voice_allocator_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : voice_allocator_if
// Description : Key-in / voice-out bundle between the note decoder, the
//               voice allocator and the oscillator/envelope stages.
// Revision    : 1.0 - initial release
// ============================================================================
interface voice_allocator_if #(
    parameter int NUM_KEYS   = 24,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = $clog2(NUM_KEYS)
);
    logic [NUM_KEYS-1:0]         gate_in;
    logic [NUM_KEYS-1:0]         trigger_in;
    logic [NUM_VOICES*KEY_W-1:0] voice_key_out;
    logic [NUM_VOICES-1:0]       voice_gate_out;
    logic [NUM_VOICES-1:0]       voice_trigger_out;
    logic [NUM_KEYS-1:0]         pending_out;

    // Upstream side: drives key levels/pulses, observes voice state
    modport master (
        output gate_in,
        output trigger_in,
        input  voice_key_out,
        input  voice_gate_out,
        input  voice_trigger_out,
        input  pending_out
    );

    // Allocator side
    modport slave (
        input  gate_in,
        input  trigger_in,
        output voice_key_out,
        output voice_gate_out,
        output voice_trigger_out,
        output pending_out
    );
endinterface
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : voice_allocator
// Description : Polyphonic voice allocator. Queues pressed keys, grants the
//               lowest pending key once per cycle to a rehit, free or stolen
//               (oldest) voice, and drives key/gate/retrigger per voice.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_KEYS   = 24,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = $clog2(NUM_KEYS),
    parameter int AGE_W      = 8
) (
    input  wire logic        clk_in,
    input  wire logic        rst_in,
    voice_allocator_if.slave bus
);

    localparam int                c_VIDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0]  c_AGE_MAX = {AGE_W{1'b1}};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_KEYS-1:0]   r_pending;
    logic [KEY_W-1:0]      r_vkey  [NUM_VOICES];
    logic [AGE_W-1:0]      r_age   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_vgate;
    logic [NUM_VOICES-1:0] r_vtrig;

    // ------------------------------------------------------------------------
    // Combinational selection
    // ------------------------------------------------------------------------
    logic                  w_cand_valid;
    logic [KEY_W-1:0]      w_cand_key;
    logic [NUM_KEYS-1:0]   w_grant_onehot;
    logic [NUM_VOICES-1:0] w_held;
    logic [NUM_VOICES-1:0] w_free;
    logic                  w_rehit_hit;
    logic [c_VIDX_W-1:0]   w_rehit_idx;
    logic                  w_free_hit;
    logic [c_VIDX_W-1:0]   w_free_idx;
    logic [c_VIDX_W-1:0]   w_old_idx;
    logic [AGE_W-1:0]      w_old_age;
    logic [c_VIDX_W-1:0]   w_sel_idx;
    logic [NUM_VOICES-1:0] w_sel_onehot;

    // Candidate is the lowest-index pending key; scanning downward lets the
    // last match (the lowest index) win.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_key   = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_cand_valid = 1'b1;
                w_cand_key   = KEY_W'(k);
            end
        end
        w_grant_onehot = w_cand_valid ? (NUM_KEYS'(1) << w_cand_key) : '0;
    end

    // A voice is free if idle or if its key has just been let go.
    always_comb begin
        w_held = '0;
        w_free = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_held[v] = bus.gate_in[r_vkey[v]];
            w_free[v] = !r_vgate[v] || !w_held[v];
        end
    end

    // Rehit and free-voice search, lowest index first.
    always_comb begin
        w_rehit_hit = 1'b0;
        w_rehit_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_vgate[v] && (r_vkey[v] == w_cand_key)) begin
                w_rehit_hit = 1'b1;
                w_rehit_idx = c_VIDX_W'(v);
            end
            if (w_free[v]) begin
                w_free_hit = 1'b1;
                w_free_idx = c_VIDX_W'(v);
            end
        end
    end

    // Steal target: largest age; strict compare keeps ties on the lowest index.
    always_comb begin
        w_old_idx = '0;
        w_old_age = r_age[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (r_age[v] > w_old_age) begin
                w_old_idx = c_VIDX_W'(v);
                w_old_age = r_age[v];
            end
        end
    end

    // Final voice choice in priority order rehit > free > steal.
    always_comb begin
        if (w_rehit_hit) begin
            w_sel_idx = w_rehit_idx;
        end else if (w_free_hit) begin
            w_sel_idx = w_free_idx;
        end else begin
            w_sel_idx = w_old_idx;
        end
        w_sel_onehot = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_sel_onehot[v] = w_cand_valid && (w_sel_idx == c_VIDX_W'(v));
        end
    end

    // ------------------------------------------------------------------------
    // Pending queue: absorb new presses, drop released keys, retire the grant.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | bus.trigger_in) & bus.gate_in & ~w_grant_onehot;
        end
    end

    // ------------------------------------------------------------------------
    // Voice pool: allocation wins over release; other active voices age.
    // The key register is left alone on release so the envelope tail keeps
    // its pitch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vgate <= '0;
            r_vtrig <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_vkey[v] <= '0;
                r_age[v]  <= '0;
            end
        end else begin
            r_vtrig <= w_sel_onehot;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_sel_onehot[v]) begin
                    r_vkey[v]  <= w_cand_key;
                    r_vgate[v] <= 1'b1;
                    r_age[v]   <= '0;
                end else begin
                    if (r_vgate[v] && (r_age[v] != c_AGE_MAX)) begin
                        r_age[v] <= r_age[v] + AGE_W'(1);
                    end
                    if (r_vgate[v] && !w_held[v]) begin
                        r_vgate[v] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------------
    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_key_out
        assign bus.voice_key_out[gv*KEY_W +: KEY_W] = r_vkey[gv];
    end

    assign bus.voice_gate_out    = r_vgate;
    assign bus.voice_trigger_out = r_vtrig;
    assign bus.pending_out       = r_pending;

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator that sits directly downstream of the touch-keyboard note decoder. It consumes the decoder's 24-bit per-key `gate` and one-cycle `trigger` vectors and assigns pressed keys to a fixed pool of synthesis voices. When the pool is full it steals the oldest voice. Per voice it drives a key index, a gate, and a one-cycle retrigger pulse to the oscillator/envelope stages.

## Interface
- `NUM_KEYS`, 24: width of the key gate/trigger vectors.
- `NUM_VOICES`, 4: voice pool size, 1..8.
- `KEY_W`, `$clog2(NUM_KEYS)` (5): key index width.
- `AGE_W`, 8: per-voice age counter width, saturating.

- `clk_in`  input  1  system clock; the block uses this one clock only.
- `rst_in`  input  1  synchronous, active-high reset.
- `gate_in`  input  NUM_KEYS  per-key held level, from the note decoder's `gate_out`.
- `trigger_in`  input  NUM_KEYS  per-key one-cycle press pulse, from the decoder's `trigger_out`.
- `voice_key_out`  output  NUM_VOICES*KEY_W  key index per voice; voice v occupies bits [v*KEY_W +: KEY_W].
- `voice_gate_out`  output  NUM_VOICES  voice active (key held).
- `voice_trigger_out`  output  NUM_VOICES  one-cycle pulse when a voice is (re)assigned.
- `pending_out`  output  NUM_KEYS  keys awaiting allocation (debug/verification).

## Operation
- **Pending register:**
  - Next value is `pending_q_next = (pending_q | trigger_in) & gate_in & ~grant_onehot`.
  - A key whose gate drops before service is discarded.
  - A trigger arriving on a key already pending is absorbed.
- **Arbitration:**
  - Each cycle, the lowest-index set bit of `pending_q` is the candidate.
  - At most one allocation happens per cycle.
- **Voice selection for the candidate key k, in priority order:**
  1. **Rehit:** an active voice already holding k. It is reused: age set to 0, trigger pulsed.
  2. **Free voice:** the lowest-index voice that is free. Free means `voice_gate_q==0`, or `gate_in[voice_key_q]==0` this cycle.
  3. **Steal:** the voice with the largest age, ties going to the lowest index. The stolen key keeps its gate but is not requeued.
- **Allocation (at the clock edge):**
  - Selected voice gets `key<=k`, `gate<=1`, `age<=0`, `trigger<=1`.
  - Every other active voice increments its age, saturating at `2^AGE_W-1`.
- **Release:**
  - A voice with `voice_gate_q==1` and `gate_in[voice_key_q]==0` gets `gate<=0` on the next edge.
  - Its `voice_key_out` holds its last value so the envelope can finish its release on the correct pitch.
  - Release and reallocation of the same voice in the same cycle: allocation wins (`gate` stays 1, trigger pulses).
- **Reset:**
  - `rst_in` clears pending, all voice keys, gates, triggers and ages to 0.
  - Reset mid-operation drops all pending and active notes. The first post-reset trigger is treated as fresh.

## Timing
- **Reset values:** all outputs are 0.
- **Registered outputs:** all outputs are registered; no combinational path from input to output.
- **Single press:** `trigger_in[k]` high in cycle t gives:
  - `pending_out[k]=1` in cycle t+1;
  - voice outputs updated and `voice_trigger_out` high in cycle t+2;
  - `voice_trigger_out` low again in cycle t+3.
- **Simultaneous presses:** j keys triggered in the same cycle t are granted in ascending key order. The i-th grant (0-based) is visible in cycle t+2+i.
- **Release latency:** `gate_in[k]` falling in cycle t gives `voice_gate_out` low in cycle t+1.
- **Pulse width:** `voice_trigger_out` is exactly one cycle wide per grant. A back-to-back rehit gives consecutive pulses.
- **Throughput:** one grant per cycle, with no bubbles between grants.

## Test plan
- **Single key:** after reset, `gate_in=trigger_in=0x000004` for 1 cycle, then gate held.
  - Cycle t+2: voice 0 has key=2, gate=1, trigger=1; cycle t+3: trigger=0.
- **Chord:** triggers on keys 0, 3, 7 in the same cycle.
  - Voices 0, 1, 2 get keys 0, 3, 7 in cycles t+2, t+3, t+4.
  - `pending_out` steps 0x89 → 0x88 → 0x80 → 0.
- **Steal:** hold keys 1, 2, 3, 4 (one trigger per cycle), then trigger key 9.
  - Voice 0 (key 1, oldest) becomes key 9 with a trigger pulse.
  - Voices 1–3 are unchanged.
- **Release and reuse:** hold keys 5, 6; drop key 5.
  - Voice 0 gate=0 in the next cycle and key output stays 5.
  - A new press on key 8 goes to voice 0.
- **Rehit and stale:**
  - Re-trigger held key 6: the same voice pulses trigger and its age resets.
  - Trigger key 10 with gate dropped the next cycle while 3 keys queue ahead of it: key 10 is never allocated.
- **Reset mid-op:** `rst_in` asserted for 1 cycle during a 4-key chord.
  - All outputs and `pending_out` are 0 the next cycle.
  - No trigger pulses until a new `trigger_in` arrives.
